// File: rtl/pc_sched.sv
// pc_sched: redirect and halt scheduler in front of the program counter.
// Resolves branch/interrupt/jump/halt requests by priority and drives the counter
// from registers one cycle later, with IF/ID flush pulses and stall buffering.
// Optional feature macro: PC_SCHED_IRQ_EN enables the interrupt path (irq_req, irq_ack, epc).
module pc_sched #(
    parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0100,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_br_req,
    input  logic [31:0] ex_br_target,
    input  logic        id_jmp_req,
    input  logic [31:0] id_jmp_target,
    input  logic        irq_req,
    input  logic        halt_instr,
    input  logic        stall_req,
    input  logic        resume,
    output logic [31:0] new_pc,
    output logic        change_pc,
    output logic        halt,
    output logic        flush_if,
    output logic        flush_id,
    output logic        irq_ack,
    output logic [31:0] epc,
    output logic        halted
);

    typedef enum logic [1:0] {StRun, StStall, StHalted} state_e;

    localparam logic [1:0]  PrioNone  = 2'd0;
    localparam logic [1:0]  PrioJmp   = 2'd1;
    localparam logic [1:0]  PrioIrq   = 2'd2;
    localparam logic [1:0]  PrioBr    = 2'd3;
    localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;
    // epc value meaning "resume at the sequential pc"
    localparam logic [31:0] EpcSeq    = 32'hFFFF_FFFF;

    state_e      state_q;
    logic        pend_valid_q;
    logic [1:0]  pend_prio_q;
    logic [31:0] pend_target_q;
    logic [31:0] pend_epc_q;
    logic [31:0] new_pc_q;
    logic [31:0] epc_q;
    logic        change_pc_q;
    logic        halt_q;
    logic        flush_if_q;
    logic        flush_id_q;
    logic        irq_ack_q;
    logic        halted_q;

    logic        irq_take;

`ifdef PC_SCHED_IRQ_EN
    // Level irq is only sampled when no interrupt is already pending or being acknowledged.
    assign irq_take = irq_req && !irq_ack_q && !(pend_valid_q && pend_prio_q == PrioIrq);
    assign irq_ack  = irq_ack_q;
    assign epc      = epc_q;
`else
    logic [33:0] unused_irq;
    assign unused_irq = {irq_req, irq_ack_q, epc_q};
    assign irq_take   = 1'b0;
    assign irq_ack    = 1'b0;
    assign epc        = '0;
`endif

    assign new_pc    = new_pc_q;
    assign change_pc = change_pc_q;
    assign halt      = halt_q;
    assign flush_if  = flush_if_q;
    assign flush_id  = flush_id_q;
    assign halted    = halted_q;

    logic        req_valid;
    logic [1:0]  req_prio;
    logic [31:0] req_target;
    logic        mrg_valid;
    logic [1:0]  mrg_prio;
    logic [31:0] mrg_target;
    logic [31:0] mrg_epc;
    logic        issue_en;
    logic [1:0]  issue_prio;
    logic [31:0] issue_target;
    logic [31:0] issue_epc;

    // Pick this cycle's winner, merge it with the pending entry, and decide what issues.
    always_comb begin
        req_valid  = 1'b0;
        req_prio   = PrioNone;
        req_target = '0;
        if (ex_br_req) begin
            req_valid  = 1'b1;
            req_prio   = PrioBr;
            req_target = ex_br_target & AlignMask;
        end else if (irq_take) begin
            req_valid  = 1'b1;
            req_prio   = PrioIrq;
            req_target = IRQ_VECTOR & AlignMask;
        end else if (id_jmp_req) begin
            req_valid  = 1'b1;
            req_prio   = PrioJmp;
            req_target = id_jmp_target & AlignMask;
        end

        // Equal or higher priority replaces the pending entry; an interrupt records
        // the redirect it displaced as its return address.
        mrg_valid  = pend_valid_q;
        mrg_prio   = pend_prio_q;
        mrg_target = pend_target_q;
        mrg_epc    = pend_epc_q;
        if (req_valid && (!pend_valid_q || req_prio >= pend_prio_q)) begin
            mrg_valid  = 1'b1;
            mrg_prio   = req_prio;
            mrg_target = req_target;
            mrg_epc    = pend_valid_q ? pend_target_q : EpcSeq;
        end

        issue_en     = 1'b0;
        issue_prio   = PrioNone;
        issue_target = mrg_target;
        issue_epc    = mrg_epc;
        unique case (state_q)
            StRun, StStall: begin
                if (!stall_req && mrg_valid) begin
                    issue_en   = 1'b1;
                    issue_prio = mrg_prio;
                end
            end
            StHalted: begin
                if (irq_take) begin
                    issue_en     = 1'b1;
                    issue_prio   = PrioIrq;
                    issue_target = IRQ_VECTOR & AlignMask;
                    issue_epc    = EpcSeq;
                end else if (resume) begin
                    issue_en     = 1'b1;
                    issue_prio   = PrioNone;
                    issue_target = RESET_VECTOR & AlignMask;
                end
            end
            default: ;
        endcase
    end

    // RUN/STALL/HALTED sequencing, pending buffer and registered counter controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            pend_valid_q  <= 1'b0;
            pend_prio_q   <= PrioNone;
            pend_target_q <= '0;
            pend_epc_q    <= '0;
            new_pc_q      <= '0;
            epc_q         <= '0;
            change_pc_q   <= 1'b0;
            halt_q        <= 1'b0;
            flush_if_q    <= 1'b0;
            flush_id_q    <= 1'b0;
            irq_ack_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            change_pc_q <= issue_en;
            flush_if_q  <= issue_en && (issue_prio != PrioNone);
            flush_id_q  <= issue_en && (issue_prio == PrioBr || issue_prio == PrioIrq);
            irq_ack_q   <= issue_en && (issue_prio == PrioIrq);
            if (issue_en) begin
                new_pc_q <= issue_target;
            end
            if (issue_en && issue_prio == PrioIrq) begin
                epc_q <= issue_epc;
            end

            unique case (state_q)
                StRun: begin
                    if (stall_req) begin
                        state_q       <= StStall;
                        halt_q        <= 1'b1;
                        pend_valid_q  <= mrg_valid;
                        pend_prio_q   <= mrg_prio;
                        pend_target_q <= mrg_target;
                        pend_epc_q    <= mrg_epc;
                    end else if (!mrg_valid && halt_instr) begin
                        state_q  <= StHalted;
                        halt_q   <= 1'b1;
                        halted_q <= 1'b1;
                    end
                end
                StStall: begin
                    if (stall_req) begin
                        pend_valid_q  <= mrg_valid;
                        pend_prio_q   <= mrg_prio;
                        pend_target_q <= mrg_target;
                        pend_epc_q    <= mrg_epc;
                    end else begin
                        state_q      <= StRun;
                        halt_q       <= 1'b0;
                        pend_valid_q <= 1'b0;
                    end
                end
                StHalted: begin
                    if (issue_en) begin
                        state_q  <= StRun;
                        halt_q   <= 1'b0;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sched.sv
// Directed self-checking bench for pc_sched; interrupt checks follow PC_SCHED_IRQ_EN.
module tb_pc_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_br_req = 1'b0;
    logic [31:0] ex_br_target = '0;
    logic        id_jmp_req = 1'b0;
    logic [31:0] id_jmp_target = '0;
    logic        irq_req = 1'b0;
    logic        halt_instr = 1'b0;
    logic        stall_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] new_pc;
    logic        change_pc;
    logic        halt;
    logic        flush_if;
    logic        flush_id;
    logic        irq_ack;
    logic [31:0] epc;
    logic        halted;

    int total = 0;
    int bad = 0;

    pc_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_br_req    (ex_br_req),
        .ex_br_target (ex_br_target),
        .id_jmp_req   (id_jmp_req),
        .id_jmp_target(id_jmp_target),
        .irq_req      (irq_req),
        .halt_instr   (halt_instr),
        .stall_req    (stall_req),
        .resume       (resume),
        .new_pc       (new_pc),
        .change_pc    (change_pc),
        .halt         (halt),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .irq_ack      (irq_ack),
        .epc          (epc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) step();
        total++; if (new_pc !== 32'h0) begin bad++; $display("FAIL rst_new_pc got=%h exp=0", new_pc); end
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL rst_change_pc got=%b exp=0", change_pc); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b exp=0", halt); end
        total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL rst_flush_if got=%b exp=0", flush_if); end
        total++; if (flush_id !== 1'b0) begin bad++; $display("FAIL rst_flush_id got=%b exp=0", flush_id); end
        total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL rst_irq_ack got=%b exp=0", irq_ack); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL rst_epc got=%h exp=0", epc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL idle_change_pc[%0d] got=%b exp=0", i, change_pc); end
            total++; if (halt !== 1'b0) begin bad++; $display("FAIL idle_halt[%0d] got=%b exp=0", i, halt); end
            total++; if (halted !== 1'b0) begin bad++; $display("FAIL idle_halted[%0d] got=%b exp=0", i, halted); end
        end
    endtask

    task automatic test_branch_vs_jump;
        ex_br_req = 1'b1; ex_br_target = 32'h40;
        id_jmp_req = 1'b1; id_jmp_target = 32'h80;
        step();
        ex_br_req = 1'b0; id_jmp_req = 1'b0;
        total++; if (new_pc !== 32'h40) begin bad++; $display("FAIL bj_new_pc got=%h exp=40", new_pc); end
        total++; if (change_pc !== 1'b1) begin bad++; $display("FAIL bj_change_pc got=%b exp=1", change_pc); end
        total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL bj_flush_if got=%b exp=1", flush_if); end
        total++; if (flush_id !== 1'b1) begin bad++; $display("FAIL bj_flush_id got=%b exp=1", flush_id); end
        total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL bj_irq_ack got=%b exp=0", irq_ack); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL bj_no_jump[%0d] got=%b exp=0", i, change_pc); end
            total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL bj_no_flush[%0d] got=%b exp=0", i, flush_if); end
        end
        total++; if (new_pc !== 32'h40) begin bad++; $display("FAIL bj_pc_held got=%h exp=40", new_pc); end
    endtask

    task automatic test_back_to_back;
        ex_br_req = 1'b1; ex_br_target = 32'h703;
        step();
        ex_br_req = 1'b0;
        id_jmp_req = 1'b1; id_jmp_target = 32'h806;
        total++; if (new_pc !== 32'h700) begin bad++; $display("FAIL b2b_br_pc got=%h exp=700", new_pc); end
        total++; if (flush_id !== 1'b1) begin bad++; $display("FAIL b2b_br_flush_id got=%b exp=1", flush_id); end
        step();
        id_jmp_req = 1'b0;
        total++; if (new_pc !== 32'h804) begin bad++; $display("FAIL b2b_jmp_pc got=%h exp=804", new_pc); end
        total++; if (change_pc !== 1'b1) begin bad++; $display("FAIL b2b_jmp_change got=%b exp=1", change_pc); end
        total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL b2b_jmp_flush_if got=%b exp=1", flush_if); end
        total++; if (flush_id !== 1'b0) begin bad++; $display("FAIL b2b_jmp_flush_id got=%b exp=0", flush_id); end
        step();
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL b2b_after got=%b exp=0", change_pc); end
    endtask

    task automatic test_stall;
        stall_req = 1'b1;
        id_jmp_req = 1'b1; id_jmp_target = 32'h123;
        for (int i = 0; i < 3; i++) begin
            step();
            id_jmp_req = 1'b0;
            if (i == 2) stall_req = 1'b0;
            total++; if (halt !== 1'b1) begin bad++; $display("FAIL stall_halt[%0d] got=%b exp=1", i, halt); end
            total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL stall_change[%0d] got=%b exp=0", i, change_pc); end
        end
        step();
        total++; if (new_pc !== 32'h120) begin bad++; $display("FAIL stall_new_pc got=%h exp=120", new_pc); end
        total++; if (change_pc !== 1'b1) begin bad++; $display("FAIL stall_issue got=%b exp=1", change_pc); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL stall_halt_drop got=%b exp=0", halt); end
        total++; if (flush_id !== 1'b0) begin bad++; $display("FAIL stall_flush_id got=%b exp=0", flush_id); end
        step();
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL stall_single got=%b exp=0", change_pc); end
    endtask

    task automatic test_stall_priority;
        stall_req = 1'b1;
        id_jmp_req = 1'b1; id_jmp_target = 32'h200;
        step();
        id_jmp_req = 1'b0;
        ex_br_req = 1'b1; ex_br_target = 32'h300;
        step();
        ex_br_req = 1'b0;
        id_jmp_req = 1'b1; id_jmp_target = 32'h400;
        step();
        id_jmp_req = 1'b0;
        stall_req = 1'b0;
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL sp_held got=%b exp=0", change_pc); end
        step();
        total++; if (new_pc !== 32'h300) begin bad++; $display("FAIL sp_new_pc got=%h exp=300", new_pc); end
        total++; if (flush_id !== 1'b1) begin bad++; $display("FAIL sp_flush_id got=%b exp=1", flush_id); end
        total++; if (change_pc !== 1'b1) begin bad++; $display("FAIL sp_change got=%b exp=1", change_pc); end
        step();
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL sp_no_second got=%b exp=0", change_pc); end
    endtask

    task automatic test_stall_empty;
        stall_req = 1'b1;
        step();
        step();
        stall_req = 1'b0;
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL se_halt got=%b exp=1", halt); end
        step();
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL se_halt_drop got=%b exp=0", halt); end
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL se_change got=%b exp=0", change_pc); end
    endtask

    task automatic test_halt_resume;
        halt_instr = 1'b1;
        step();
        halt_instr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (halt !== 1'b1) begin bad++; $display("FAIL hr_halt[%0d] got=%b exp=1", i, halt); end
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL hr_halted[%0d] got=%b exp=1", i, halted); end
            total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL hr_change[%0d] got=%b exp=0", i, change_pc); end
            if (i == 1) begin ex_br_req = 1'b1; ex_br_target = 32'h900; end
            if (i == 2) begin id_jmp_req = 1'b1; id_jmp_target = 32'hA00; end
            step();
            ex_br_req = 1'b0; id_jmp_req = 1'b0;
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        total++; if (new_pc !== 32'h0) begin bad++; $display("FAIL hr_new_pc got=%h exp=0", new_pc); end
        total++; if (change_pc !== 1'b1) begin bad++; $display("FAIL hr_change got=%b exp=1", change_pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL hr_halted_drop got=%b exp=0", halted); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL hr_halt_drop got=%b exp=0", halt); end
        step();
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL hr_single got=%b exp=0", change_pc); end
    endtask

`ifdef PC_SCHED_IRQ_EN
    task automatic test_irq;
        halt_instr = 1'b1;
        step();
        halt_instr = 1'b0;
        irq_req = 1'b1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL irqh_halted got=%b exp=1", halted); end
        step();
        irq_req = 1'b0;
        total++; if (new_pc !== 32'h100) begin bad++; $display("FAIL irqh_new_pc got=%h exp=100", new_pc); end
        total++; if (irq_ack !== 1'b1) begin bad++; $display("FAIL irqh_ack got=%b exp=1", irq_ack); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL irqh_halted_drop got=%b exp=0", halted); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL irqh_halt_drop got=%b exp=0", halt); end
        total++; if (epc !== 32'hFFFF_FFFF) begin bad++; $display("FAIL irqh_epc got=%h exp=ffffffff", epc); end
        step();
        total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL irqh_ack_pulse got=%b exp=0", irq_ack); end
        // Level irq held two cycles in RUN: exactly one acknowledge.
        irq_req = 1'b1;
        step();
        total++; if (irq_ack !== 1'b1) begin bad++; $display("FAIL irqr_ack got=%b exp=1", irq_ack); end
        total++; if (flush_id !== 1'b1) begin bad++; $display("FAIL irqr_flush_id got=%b exp=1", flush_id); end
        step();
        irq_req = 1'b0;
        total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL irqr_double got=%b exp=0", irq_ack); end
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL irqr_change got=%b exp=0", change_pc); end
        // Interrupt during a stall displaces a buffered jump and records it in epc.
        stall_req = 1'b1;
        id_jmp_req = 1'b1; id_jmp_target = 32'h500;
        step();
        id_jmp_req = 1'b0;
        irq_req = 1'b1;
        step();
        irq_req = 1'b0;
        stall_req = 1'b0;
        step();
        total++; if (new_pc !== 32'h100) begin bad++; $display("FAIL irqs_new_pc got=%h exp=100", new_pc); end
        total++; if (irq_ack !== 1'b1) begin bad++; $display("FAIL irqs_ack got=%b exp=1", irq_ack); end
        total++; if (epc !== 32'h500) begin bad++; $display("FAIL irqs_epc got=%h exp=500", epc); end
        step();
    endtask
`else
    task automatic test_irq;
        irq_req = 1'b1;
        step();
        irq_req = 1'b0;
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL noirq_change got=%b exp=0", change_pc); end
        total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL noirq_ack got=%b exp=0", irq_ack); end
        halt_instr = 1'b1;
        step();
        halt_instr = 1'b0;
        irq_req = 1'b1;
        step();
        step();
        irq_req = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL noirq_halted got=%b exp=1", halted); end
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL noirq_h_change got=%b exp=0", change_pc); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL noirq_epc got=%h exp=0", epc); end
        resume = 1'b1;
        step();
        resume = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL noirq_resume got=%b exp=0", halted); end
        step();
    endtask
`endif

    task automatic test_reset_mid;
        stall_req = 1'b1;
        id_jmp_req = 1'b1; id_jmp_target = 32'h600;
        step();
        id_jmp_req = 1'b0;
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL rm_halt got=%b exp=1", halt); end
        stall_req = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL rm_halt_async got=%b exp=0", halt); end
        total++; if (new_pc !== 32'h0) begin bad++; $display("FAIL rm_new_pc got=%h exp=0", new_pc); end
        total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL rm_change got=%b exp=0", change_pc); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (change_pc !== 1'b0) begin bad++; $display("FAIL rm_after[%0d] got=%b exp=0", i, change_pc); end
            total++; if (halt !== 1'b0) begin bad++; $display("FAIL rm_halt_after[%0d] got=%b exp=0", i, halt); end
        end
    endtask

    initial begin
        test_reset();
        test_branch_vs_jump();
        test_back_to_back();
        test_stall();
        test_stall_priority();
        test_stall_empty();
        test_halt_resume();
        test_irq();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
